mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single external memory port between the instruction-fetch path and the load/store data path of the MIPS core. Each requester gets a req/ack handshake and the memory side gets one registered request channel. A `stall` output tells the controller to freeze `iaddr` and hold the current instruction. A bounded-wait timeout turns a hung memory into an error pulse instead of a dead core.

## Interface
- `MAX_WAIT`, 15: last BUSY cycle index before abort; `m_req` is held for at most MAX_WAIT+1 cycles.
- `BAD_DATA`, 32'hDEADBEEF: read data returned on a timed-out read.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: fetch request; held until `i_ack`.
- `i_addr` in 30: word address [31:2].
- `i_rdata` out 32: fetched word; valid while `i_ack`=1.
- `i_ack` out 1: one-cycle completion pulse.
- `d_req` in 1: data request; held until `d_ack`.
- `d_rw` in 1: 1 = write, 0 = read.
- `d_addr` in 30: word address.
- `d_wdata` in 32: write data.
- `d_be` in 4: byte enables.
- `d_rdata` out 32: load word; valid while `d_ack`=1.
- `d_ack` out 1: one-cycle completion pulse.
- `m_req` out 1: memory request; registered.
- `m_rw` out 1: registered copy of the granted request.
- `m_addr` out 30: registered copy of the granted request.
- `m_wdata` out 32: registered copy of the granted request.
- `m_be` out 4: registered copy of the granted request; 4'hF for fetch.
- `m_rdata` in 32: memory read data; sampled when `m_ack`=1.
- `m_ack` in 1: memory completion; valid only while `m_req`=1.
- `stall` out 1: combinational; `(i_req & ~i_ack) | (d_req & ~d_ack)`.
- `err` out 1: one-cycle pulse concurrent with the ack of an aborted transaction.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - A requester whose ack is high this cycle is ineligible. This prevents re-granting a request that is being retired.
  - If eligible requests are present, grant one, load `m_*` from its fields, set `m_req`=1, clear `wait_cnt`, and go to the matching BUSY state.
  - Fetch grants force `m_rw`=0 and `m_be`=4'hF.
- BUSY_x, `m_ack`=1: capture `m_rdata` into `x_rdata` (reads only), pulse `x_ack`, clear `m_req`, return to IDLE.
- BUSY_x, `m_ack`=0 and `wait_cnt`==MAX_WAIT: abort.
  - Clear `m_req` and pulse `x_ack` and `err`.
  - Reads load `x_rdata`=BAD_DATA.
  - Return to IDLE.
- BUSY_x, otherwise: `wait_cnt`+=1. The counter is wide enough for MAX_WAIT and never wraps.
- When `m_ack` and timeout coincide, `m_ack` wins: normal completion, no `err`.
- `m_ack` while IDLE is ignored.
- A requester dropping req before its ack is a protocol violation. The transaction still completes and the ack still pulses.
- The `x_rdata` registers hold their value between transactions. They are not updated on writes.
- Reset values:
  - state=IDLE, `wait_cnt`=0.
  - `m_req`=`m_rw`=0, `m_addr`=0, `m_wdata`=0, `m_be`=0.
  - `i_ack`=`d_ack`=`err`=0, `i_rdata`=`d_rdata`=0.
  - Last-grant flag = fetch.
- Reset mid-transaction: `m_req` drops at that edge, and no ack or `err` is issued.

## Timing
- Request sampled at edge N in IDLE → `m_req`=1 during cycle N+1.
- `m_ack` in cycle K → `x_ack`/`x_rdata` valid in cycle K+1. The state is IDLE in K+1.
- Zero-wait memory: `x_req` rises in cycle 0, `m_req`/`m_ack` are high in cycle 1, `x_ack` is high in cycle 2. That is 2 cycles latency.
- Back-to-back transactions to different requesters: the ack cycle of one can grant the other. The result is one dead `m_req` cycle between transactions.
- Same requester: earliest re-grant is the cycle after its ack.
- Timeout: `m_req` is high for exactly MAX_WAIT+1 cycles; `err` and `ack` follow in the next cycle.

## Configuration
- `MEM_PORT_ARB_RR_EN` defined:
  - When both are eligible in IDLE, grant the requester not granted last.
  - The last-grant flag updates on every grant.
  - After reset, data wins the first tie.
- `MEM_PORT_ARB_RR_EN` undefined: fixed priority, data over fetch. The last-grant flag is not implemented.

## Test plan
- Reset, then fetch of `i_addr`=30'h10 with `m_ack` in the first `m_req` cycle and `m_rdata`=32'h24020005 → `m_addr`=30'h10, `m_be`=4'hF; `i_ack` and `i_rdata`=32'h24020005 arrive 2 cycles after `i_req`; `stall` falls with `i_ack`.
- Data write: `d_addr`=30'h40, `d_wdata`=32'hCAFEF00D, `d_be`=4'b0011, memory waits 3 cycles → `m_rw`=1 with all fields held for 4 cycles; `d_ack` one cycle after `m_ack`; `d_rdata` unchanged.
- `i_req` and `d_req` asserted in the same cycle, repeatedly → fixed build: data granted first every time. RR build: D, I, D, I alternation.
- Memory never acks, MAX_WAIT=15 → `m_req` high 16 cycles; then `err`=1, `d_ack`=1, `d_rdata`=32'hDEADBEEF on a read.
- `m_ack` arrives on cycle 16 exactly (coincident with timeout) → normal completion, `err`=0. Stray `m_ack` while IDLE → no ack, no state change.
- Reset asserted during BUSY_D → `m_req`=0 on the next edge; no `d_ack` or `err`; all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three handshake channels of the memory port arbiter:
//   fetch requester (i_*), load/store requester (d_*), external memory (m_*),
//   plus the stall and err status outputs.
//   Modports:
//     slave  - the arbiter itself (drives acks, read data, m_* request, stall, err)
//     master - the surrounding core and memory (drive requests, m_rdata, m_ack)
interface mem_port_arbiter_if;
   // Fetch requester
   logic        i_req;
   logic [29:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ack;
   // Load/store requester
   logic        d_req;
   logic        d_rw;
   logic [29:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_ack;
   // Memory channel
   logic        m_req;
   logic        m_rw;
   logic [29:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic [31:0] m_rdata;
   logic        m_ack;
   // Status
   logic        stall;
   logic        err;

   modport slave (
      input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, d_be, m_rdata, m_ack,
      output i_rdata, i_ack, d_rdata, d_ack, m_req, m_rw, m_addr, m_wdata, m_be,
             stall, err
   );

   modport master (
      output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, d_be, m_rdata, m_ack,
      input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_rw, m_addr, m_wdata, m_be,
             stall, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between instruction fetch and the
//   load/store path. Each requester holds req until a one-cycle ack; the
//   granted request is copied into registered m_* outputs. A bounded wait
//   (MAX_WAIT) aborts a hung access with an err pulse and BAD_DATA on reads.
//   Ports:
//     clk    - clock, all state on posedge
//     reset  - synchronous, active-high
//     bus    - mem_port_arbiter_if.slave (i_*, d_*, m_*, stall, err)
//   Parameters:
//     MAX_WAIT - last BUSY cycle index before abort (m_req held <= MAX_WAIT+1)
//     BAD_DATA - read data returned on an aborted read
//   Build option:
//     MEM_PORT_ARB_RR_EN - round-robin on ties (data wins the first tie after
//                          reset); undefined gives fixed data-over-fetch priority.
module mem_port_arbiter #(
   parameter int          MAX_WAIT = 15,
   parameter logic [31:0] BAD_DATA = 32'hDEADBEEF
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);

   localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             i_elig;
   logic             d_elig;
   logic             grant_d;
   logic             grant_i;
   logic             timeout;

   // A requester being acked this cycle still shows req high; skip it so the
   // retiring transaction is not granted a second time.
   assign i_elig = bus.i_req & ~bus.i_ack;
   assign d_elig = bus.d_req & ~bus.d_ack;

`ifdef MEM_PORT_ARB_RR_EN
   logic last_d;   // 1 = data was granted last, 0 = fetch

   assign grant_d = d_elig & (~i_elig | ~last_d);
`else
   assign grant_d = d_elig;
`endif
   assign grant_i = i_elig & ~grant_d;

   assign timeout = (wait_cnt == CNT_W'(MAX_WAIT));

   assign bus.stall = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         bus.m_req   <= 1'b0;
         bus.m_rw    <= 1'b0;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
         bus.m_be    <= '0;
         bus.i_ack   <= 1'b0;
         bus.d_ack   <= 1'b0;
         bus.err     <= 1'b0;
         bus.i_rdata <= '0;
         bus.d_rdata <= '0;
`ifdef MEM_PORT_ARB_RR_EN
         last_d      <= 1'b0;
`endif
      end else begin
         bus.i_ack <= 1'b0;
         bus.d_ack <= 1'b0;
         bus.err   <= 1'b0;

         case (state)
            IDLE: begin
               if (grant_d) begin
                  bus.m_req   <= 1'b1;
                  bus.m_rw    <= bus.d_rw;
                  bus.m_addr  <= bus.d_addr;
                  bus.m_wdata <= bus.d_wdata;
                  bus.m_be    <= bus.d_be;
                  wait_cnt    <= '0;
                  state       <= BUSY_D;
`ifdef MEM_PORT_ARB_RR_EN
                  last_d      <= 1'b1;
`endif
               end else if (grant_i) begin
                  // Fetches are always full-word reads; no write data.
                  bus.m_req   <= 1'b1;
                  bus.m_rw    <= 1'b0;
                  bus.m_addr  <= bus.i_addr;
                  bus.m_wdata <= '0;
                  bus.m_be    <= 4'hF;
                  wait_cnt    <= '0;
                  state       <= BUSY_I;
`ifdef MEM_PORT_ARB_RR_EN
                  last_d      <= 1'b0;
`endif
               end
            end

            BUSY_I, BUSY_D: begin
               // m_ack is tested first so it wins over a coincident timeout.
               if (bus.m_ack || timeout) begin
                  bus.m_req <= 1'b0;
                  bus.err   <= ~bus.m_ack;
                  state     <= IDLE;
                  if (state == BUSY_I) begin
                     bus.i_ack   <= 1'b1;
                     bus.i_rdata <= bus.m_ack ? bus.m_rdata : BAD_DATA;
                  end else begin
                     bus.d_ack <= 1'b1;
                     if (!bus.m_rw) begin
                        bus.d_rdata <= bus.m_ack ? bus.m_rdata : BAD_DATA;
                     end
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            default: begin
               bus.m_req <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
